// File: rtl/execute_unit_if.sv
// ----------------------------------------------------------------------------
// execute_unit_if
//   Bundles the fetch-stage <-> execute-stage signals of the execute unit.
//
//   Handshake: there is no valid/ready pair. The execute stage accepts one
//   instruction (value, is_load_in, opcode_in) on every rising edge where
//   stall is low. While stall is high the execute stage ignores these
//   inputs, and the fetch stage must keep presenting the instruction it
//   wants executed next.
//
//   Signals
//     value       fetch -> exec  16  operand (register, immediate or data)
//     is_load_in  fetch -> exec   1  load request, overrides opcode_in
//     opcode_in   fetch -> exec   4  operation select
//     alu_result  exec -> fetch  16  accumulator, writeback data
//     zero        exec -> fetch   1  accumulator == 0 status flag
//     carry       exec -> fetch   1  carry / borrow / shifted-out bit
//     stall       exec -> fetch   1  multiply in progress
//
//   Modports: master = fetch-stage side, slave = execute-unit side.
// ----------------------------------------------------------------------------
interface execute_unit_if;
    logic [15:0] value;
    logic        is_load_in;
    logic [3:0]  opcode_in;
    logic [15:0] alu_result;
    logic        zero;
    logic        carry;
    logic        stall;

    modport master (
        output value,
        output is_load_in,
        output opcode_in,
        input  alu_result,
        input  zero,
        input  carry,
        input  stall
    );

    modport slave (
        input  value,
        input  is_load_in,
        input  opcode_in,
        output alu_result,
        output zero,
        output carry,
        output stall
    );
endinterface

// File: rtl/execute_unit.sv
// ----------------------------------------------------------------------------
// execute_unit
//   Accumulator-based execute stage. Single-cycle ALU operations on a 16-bit
//   accumulator plus an optional 16-cycle shift-and-add multiply that stalls
//   the fetch stage while it runs.
//
//   Parameters
//     MUL_EN   1 = opcode 8 runs the multiply, 0 = opcode 8 is a NOP
//
//   Ports
//     clk      in   clock, rising edge
//     rst      in   asynchronous reset, active low
//     bus      slave modport of execute_unit_if (operands, result, flags,
//              stall)
//     state_o  out  current FSM state (0 = IDLE, 1 = MUL), for observation
// ----------------------------------------------------------------------------
module execute_unit #(
    parameter int MUL_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    execute_unit_if.slave        bus,
    output logic                 state_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_NOT = 4'd9;

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic        zero_q, zero_d;
    logic        carry_q, carry_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [15:0] prod_q, prod_d;
    logic [3:0]  count_q, count_d;

    logic [16:0] sum;
    logic [15:0] prod_step;
    logic        acc_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= 16'd0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            mcand_q  <= 16'd0;
            mplier_q <= 16'd0;
            prod_q   <= 16'd0;
            count_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        count_d  = count_q;
        sum      = 17'd0;
        acc_wr   = 1'b0;
        // Partial product including the current multiplier bit; on the last
        // step this is the finished product.
        prod_step = prod_q + (mplier_q[0] ? mcand_q : 16'd0);

        case (state_q)
            ST_IDLE: begin
                if (bus.is_load_in) begin
                    // Load wins over any opcode presented alongside it.
                    acc_d   = bus.value;
                    carry_d = 1'b0;
                    acc_wr  = 1'b1;
                end else begin
                    case (bus.opcode_in)
                        OP_ADD: begin
                            sum     = {1'b0, acc_q} + {1'b0, bus.value};
                            acc_d   = sum[15:0];
                            carry_d = sum[16];
                            acc_wr  = 1'b1;
                        end
                        OP_SUB: begin
                            // Bit 16 of the 17-bit difference is the borrow.
                            sum     = {1'b0, acc_q} - {1'b0, bus.value};
                            acc_d   = sum[15:0];
                            carry_d = sum[16];
                            acc_wr  = 1'b1;
                        end
                        OP_AND: begin
                            acc_d   = acc_q & bus.value;
                            carry_d = 1'b0;
                            acc_wr  = 1'b1;
                        end
                        OP_OR: begin
                            acc_d   = acc_q | bus.value;
                            carry_d = 1'b0;
                            acc_wr  = 1'b1;
                        end
                        OP_XOR: begin
                            acc_d   = acc_q ^ bus.value;
                            carry_d = 1'b0;
                            acc_wr  = 1'b1;
                        end
                        OP_SHL: begin
                            acc_d   = {acc_q[14:0], 1'b0};
                            carry_d = acc_q[15];
                            acc_wr  = 1'b1;
                        end
                        OP_SHR: begin
                            acc_d   = {1'b0, acc_q[15:1]};
                            carry_d = acc_q[0];
                            acc_wr  = 1'b1;
                        end
                        OP_NOT: begin
                            acc_d   = ~acc_q;
                            carry_d = 1'b0;
                            acc_wr  = 1'b1;
                        end
                        OP_MUL: begin
                            if (MUL_EN != 0) begin
                                state_d  = ST_MUL;
                                mcand_d  = acc_q;
                                mplier_d = bus.value;
                                prod_d   = 16'd0;
                                count_d  = 4'd0;
                            end
                        end
                        default: ;
                    endcase
                end
                if (acc_wr) begin
                    zero_d = (acc_d == 16'd0);
                end
            end

            ST_MUL: begin
                // Inputs are ignored here; acc and flags hold until the
                // sixteenth step.
                prod_d   = prod_step;
                mcand_d  = {mcand_q[14:0], 1'b0};
                mplier_d = {1'b0, mplier_q[15:1]};
                count_d  = count_q + 4'd1;
                if (count_q == 4'd15) begin
                    acc_d   = prod_step;
                    zero_d  = (prod_step == 16'd0);
                    carry_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.alu_result = acc_q;
    assign bus.zero       = zero_q;
    assign bus.carry      = carry_q;
    assign bus.stall      = (state_q == ST_MUL);
    assign state_o        = state_q;

endmodule
